systolic_mm_engine: RTL and testbench

Self-sequencing, output-stationary systolic matrix-multiply engine. It computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS] in signed fixed point, with a run-time depth K. Input skewing, per-PE control generation, the drain sequence and the ready/valid handshakes are all internal. It sits between the input/weight buffers and the output buffer, and replaces the externally controlled PE grid.

---
 rtl/sa_pkg.sv | 37 +++
 rtl/systolic_mm_engine_if.sv | 38 +++
 rtl/sa_pe.sv | 51 +++++
 rtl/systolic_mm_engine.sv | 203 ++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: types and helpers shared by the systolic matrix-multiply engine.
//   sa_state_e   : controller state encoding
//   sa_acc_w     : accumulator width so that K products of 2*WIDTH bits never wrap
//   sa_sat_shift : fixed-point rescale (optional round half up) plus clamp to WIDTH
package sa_pkg;

  typedef enum logic [1:0] {
    SA_IDLE,
    SA_FEED,
    SA_FLUSH,
    SA_DRAIN
  } sa_state_e;

  function automatic int sa_acc_w(input int width, input int kmax);
    return 2 * width + $clog2(kmax);
  endfunction

  // Operates on a 64-bit sign-extended copy of the accumulator so one
  // function serves every parameterisation; the caller keeps the low WIDTH bits.
  function automatic logic signed [63:0] sa_sat_shift(input logic signed [63:0] acc,
                                                      input int width,
                                                      input int decimal,
                                                      input bit round_en);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = acc;
    if (round_en && decimal > 0) v = v + (64'sd1 <<< (decimal - 1));
    v  = v >>> decimal;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// systolic_mm_engine_if: command, feed and drain signals of the engine.
//   start/k_len/busy            : operation control
//   in_valid/in_ready/ins/ws    : B row (ins, lane per column) and A column (ws, lane per row)
//   out_valid/out_ready/outs    : one saturated C row per beat
//   out_row/out_last            : row index of outs and final-row flag
// master = upstream/downstream side, slave = engine.
interface systolic_mm_engine_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int KMAX  = 16
);
  localparam int KL_W  = $clog2(KMAX + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                    start;
  logic [KL_W-1:0]         k_len;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic [COLS*WIDTH-1:0]   ins;
  logic [ROWS*WIDTH-1:0]   ws;
  logic                    out_valid;
  logic                    out_ready;
  logic [COLS*WIDTH-1:0]   outs;
  logic [ROW_W-1:0]        out_row;
  logic                    out_last;

  modport master (
    output start, k_len, in_valid, ins, ws, out_ready,
    input  busy, in_ready, out_valid, outs, out_row, out_last
  );

  modport slave (
    input  start, k_len, in_valid, ins, ws, out_ready,
    output busy, in_ready, out_valid, outs, out_row, out_last
  );
endinterface

// File: rtl/sa_pe.sv
// sa_pe: one output-stationary processing element.
//   i_adv         : array advance; acc += i_in * i_w and register the pass-through values
//   i_drain_shift : load accumulator from the PE below (mutually exclusive with i_adv)
//   i_clr         : clear accumulator and pass-through registers
//   i_in / o_in   : B operand entering from above / passed down
//   i_w  / o_w    : A operand entering from the left / passed right
//   i_acc_below   : accumulator of the PE below (zero for the bottom row)
//   o_acc         : this PE's accumulator
module sa_pe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_adv,
  input  logic                    i_drain_shift,
  input  logic                    i_clr,
  input  logic signed [WIDTH-1:0] i_in,
  input  logic signed [WIDTH-1:0] i_w,
  input  logic signed [ACC_W-1:0] i_acc_below,
  output logic signed [WIDTH-1:0] o_in,
  output logic signed [WIDTH-1:0] o_w,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [WIDTH-1:0]   r_in;
  logic signed [WIDTH-1:0]   r_w;

  assign w_prod = i_in * i_w;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_acc <= '0;
      r_in  <= '0;
      r_w   <= '0;
    end else if (i_adv) begin
      r_acc <= r_acc + ACC_W'(w_prod);
      r_in  <= i_in;
      r_w   <= i_w;
    end else if (i_drain_shift) begin
      r_acc <= i_acc_below;
    end
  end

  assign o_in  = r_in;
  assign o_w   = r_w;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: self-sequencing output-stationary systolic matmul,
// C[ROWS x COLS] = A[ROWS x K] * B[K x COLS], signed Q(WIDTH-DECIMAL).DECIMAL.
//   clk, rst (synchronous, active-low)
//   bus (slave modport of systolic_mm_engine_if): start/k_len/busy,
//       in_valid/in_ready/ins/ws feed, out_valid/out_ready/outs/out_row/out_last drain
// Build option: SA_ROUND_EN adds round-half-up before the output rescale;
// otherwise the rescale truncates toward minus infinity.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SA_IDLE  | waiting for start with k_len != 0
// SA_FEED  | one array advance per accepted in_valid beat, K beats
// SA_FLUSH | zeros injected, array advances every cycle, ROWS+COLS-2 cycles
// SA_DRAIN | row 0 presented on outs, accumulators shift up per beat
module systolic_mm_engine
  import sa_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DECIMAL = 4,
  parameter int ROWS    = 3,
  parameter int COLS    = 4,
  parameter int KMAX    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_mm_engine_if.slave  bus
);

  localparam int ACC_W = sa_acc_w(WIDTH, KMAX);
  localparam int F     = ROWS + COLS - 2;
  localparam int KL_W  = $clog2(KMAX + 1);
  localparam int CNT_W = $clog2(((KMAX > F) ? KMAX : F) + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef SA_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  sa_state_e        r_state;
  sa_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] w_k_sat;
  logic             w_adv;
  logic             w_clr;
  logic             w_shift;
  logic             w_busy;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_out_last;
  logic [COLS*WIDTH-1:0] w_outs;

  // w_a[r][c]: A operand entering PE(r,c); column COLS is the unused tail.
  // w_b[r][c]: B operand entering PE(r,c); row ROWS is the unused tail.
  // w_acc[ROWS][c] is the zero fed into the bottom row during drain.
  logic signed [WIDTH-1:0] w_a   [ROWS][COLS+1];
  logic signed [WIDTH-1:0] w_b   [ROWS+1][COLS];
  logic signed [ACC_W-1:0] w_acc [ROWS+1][COLS];

  assign w_k_sat = (bus.k_len > KL_W'(KMAX)) ? CNT_W'(KMAX) : CNT_W'(bus.k_len);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= SA_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_busy      = (r_state != SA_IDLE);
    w_in_ready  = (r_state == SA_FEED);
    w_out_valid = (r_state == SA_DRAIN);
    w_out_last  = (r_state == SA_DRAIN) && (r_row == ROW_W'(ROWS - 1));
    case (r_state)
      SA_IDLE: begin
        if (bus.start && (bus.k_len != '0)) begin
          w_clr       = 1'b1;
          w_state_nxt = SA_FEED;
        end
      end
      SA_FEED: begin
        if (bus.in_valid) begin
          w_adv = 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_nxt = (F == 0) ? SA_DRAIN : SA_FLUSH;
        end
      end
      SA_FLUSH: begin
        w_adv = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = SA_DRAIN;
      end
      SA_DRAIN: begin
        if (bus.out_ready) begin
          w_shift = 1'b1;
          if (r_row == ROW_W'(ROWS - 1)) w_state_nxt = SA_IDLE;
        end
      end
      default: w_state_nxt = SA_IDLE;
    endcase
  end

  // r_cnt counts down FEED beats, then is reloaded with the flush length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_row <= '0;
    end else begin
      case (r_state)
        SA_IDLE: begin
          if (w_clr) begin
            r_cnt <= w_k_sat;
            r_row <= '0;
          end
        end
        SA_FEED: begin
          if (w_adv) r_cnt <= (r_cnt == CNT_W'(1)) ? CNT_W'(F) : r_cnt - CNT_W'(1);
        end
        SA_FLUSH: r_cnt <= r_cnt - CNT_W'(1);
        SA_DRAIN: begin
          if (w_shift) r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

  // A lane r is delayed r advances so that A[r][k] meets B[k][c] at PE(r,c).
  for (genvar r = 0; r < ROWS; r++) begin : g_ws_skew
    logic signed [WIDTH-1:0] w_head;
    assign w_head = (r_state == SA_FEED) ? bus.ws[r*WIDTH +: WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign w_a[r][0] = w_head;
    end else begin : g_chain
      logic signed [WIDTH-1:0] r_sk [r];
      always_ff @(posedge clk) begin
        if (!rst || w_clr) begin
          for (int i = 0; i < r; i++) r_sk[i] <= '0;
        end else if (w_adv) begin
          r_sk[0] <= w_head;
          for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_a[r][0] = r_sk[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_ins_skew
    logic signed [WIDTH-1:0] w_head;
    assign w_head = (r_state == SA_FEED) ? bus.ins[c*WIDTH +: WIDTH] : '0;
    assign w_acc[ROWS][c] = '0;
    if (c == 0) begin : g_direct
      assign w_b[0][c] = w_head;
    end else begin : g_chain
      logic signed [WIDTH-1:0] r_sk [c];
      always_ff @(posedge clk) begin
        if (!rst || w_clr) begin
          for (int i = 0; i < c; i++) r_sk[i] <= '0;
        end else if (w_adv) begin
          r_sk[0] <= w_head;
          for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_b[0][c] = r_sk[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_pe (
        .clk           (clk),
        .rst           (rst),
        .i_adv         (w_adv),
        .i_drain_shift (w_shift),
        .i_clr         (w_clr),
        .i_in          (w_b[r][c]),
        .i_w           (w_a[r][c]),
        .i_acc_below   (w_acc[r+1][c]),
        .o_in          (w_b[r+1][c]),
        .o_w           (w_a[r][c+1]),
        .o_acc         (w_acc[r][c])
      );
    end
  end

  // Row 0 is always the row on display; drain shifts the others into it.
  always_comb begin
    w_outs = '0;
    for (int c = 0; c < COLS; c++) begin
      w_outs[c*WIDTH +: WIDTH] = WIDTH'(sa_sat_shift(64'(w_acc[0][c]), WIDTH, DECIMAL, ROUND_EN));
    end
  end

  assign bus.busy      = w_busy;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.outs      = w_outs;
  assign bus.out_row   = r_row;
  assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: table-driven bench for systolic_mm_engine (ROWS=3, COLS=4, KMAX=16, Q4.4).
module tb_systolic_mm_engine;
  localparam int W  = 8;
  localparam int R  = 3;
  localparam int C  = 4;
  localparam int KM = 16;
  localparam int NV = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_mm_engine_if #(.WIDTH(W), .ROWS(R), .COLS(C), .KMAX(KM)) bus ();

  systolic_mm_engine #(.WIDTH(W), .DECIMAL(4), .ROWS(R), .COLS(C), .KMAX(KM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    int         k;
    logic [7:0] a [R][KM];
    logic [7:0] b [KM][C];
    logic [7:0] c [R][C];
  } vec_t;

`ifdef SA_ROUND_EN
  localparam logic [7:0] EXP_SMALL_POS = 8'h01;
  localparam logic [7:0] EXP_SMALL_NEG = 8'h00;
`else
  localparam logic [7:0] EXP_SMALL_POS = 8'h00;
  localparam logic [7:0] EXP_SMALL_NEG = 8'hFF;
`endif

  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_uniform(input int i, input string n, input int k,
                             input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
    vecs[i].name = n;
    vecs[i].k    = k;
    for (int r = 0; r < R; r++)
      for (int kk = 0; kk < KM; kk++) vecs[i].a[r][kk] = (kk < k) ? av : 8'h00;
    for (int kk = 0; kk < KM; kk++)
      for (int c = 0; c < C; c++) vecs[i].b[kk][c] = (kk < k) ? bv : 8'h00;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) vecs[i].c[r][c] = cv;
  endtask

  task automatic fill_vectors();
    logic [7:0] mixed [R][C];
    set_uniform(0, "unit",      1,  8'h10, 8'h20, 8'h20);
    // identity: C rows equal B rows {1..4},{5..8},{9..12} x 0x10
    set_uniform(1, "ident",     3,  8'h00, 8'h00, 8'h00);
    for (int r = 0; r < R; r++) vecs[1].a[r][r] = 8'h10;
    for (int kk = 0; kk < 3; kk++)
      for (int c = 0; c < C; c++) vecs[1].b[kk][c] = 8'((kk * 4 + c + 1) * 16);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) vecs[1].c[r][c] = 8'((r * 4 + c + 1) * 16);
    set_uniform(2, "pos_sat",   16, 8'h7F, 8'h7F, 8'h7F);
    set_uniform(3, "neg_sat",   16, 8'h7F, 8'h80, 8'h80);
    set_uniform(4, "small_pos", 1,  8'h01, 8'h08, EXP_SMALL_POS);
    set_uniform(5, "small_neg", 1,  8'hFF, 8'h08, EXP_SMALL_NEG);
    // mixed: A[r] = {r+1, -0.5}, B = {1,1,1,1},{0,1,2,3} -> C = (r+1) - 0.5c
    set_uniform(6, "mixed",     2,  8'h00, 8'h00, 8'h00);
    for (int r = 0; r < R; r++) begin
      vecs[6].a[r][0] = 8'((r + 1) * 16);
      vecs[6].a[r][1] = 8'hF8;
    end
    for (int c = 0; c < C; c++) begin
      vecs[6].b[0][c] = 8'h10;
      vecs[6].b[1][c] = 8'(c * 16);
    end
    mixed[0] = '{8'h10, 8'h08, 8'h00, 8'hF8};
    mixed[1] = '{8'h20, 8'h18, 8'h10, 8'h08};
    mixed[2] = '{8'h30, 8'h28, 8'h20, 8'h18};
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) vecs[6].c[r][c] = mixed[r][c];
  endtask

  // One full operation; n counts cycles since the start-accept edge.
  task automatic run_op(input int vi, input bit gaps, input int stall_row);
    int           n;
    int           beat;
    int           stalls;
    logic [C*W-1:0] exp_row;
    vec_t         v;
    v = vecs[vi];
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 5'(v.k);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1; stalls = 0; beat = 0;
    chk({v.name, " busy"}, 64'(bus.busy), 64'd1);
    while (beat < v.k && n < 400) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        stalls++;
      end else begin
        chk({v.name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        for (int r = 0; r < R; r++) bus.ws[r*W +: W] = v.a[r][beat];
        for (int c = 0; c < C; c++) bus.ins[c*W +: W] = v.b[beat][c];
        beat++;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    bus.ws  = '0;
    bus.ins = '0;
    chk({v.name, " in_ready_after_feed"}, 64'(bus.in_ready), 64'd0);
    while (!bus.out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, " first_valid_latency"}, 64'(n), 64'(v.k + R + C - 1 + stalls));
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) exp_row[c*W +: W] = v.c[r][c];
      if (r == stall_row) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk({v.name, " stall_valid"}, 64'(bus.out_valid), 64'd1);
          chk({v.name, " stall_outs"},  64'(bus.outs), 64'(exp_row));
          chk({v.name, " stall_row"},   64'(bus.out_row), 64'(r));
          chk({v.name, " stall_last"},  64'(bus.out_last), 64'(r == R - 1));
          @(negedge clk);
          n++;
          stalls++;
        end
        bus.out_ready = 1'b1;
      end
      chk({v.name, " out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({v.name, " outs"},      64'(bus.outs), 64'(exp_row));
      chk({v.name, " out_row"},   64'(bus.out_row), 64'(r));
      chk({v.name, " out_last"},  64'(bus.out_last), 64'(r == R - 1));
      @(negedge clk);
      n++;
    end
    chk({v.name, " busy_after_drain"}, 64'(bus.busy), 64'd0);
    chk({v.name, " end_latency"}, 64'(n), 64'(v.k + R + C - 1 + R + stalls));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"},      64'(bus.busy), 64'd0);
    chk({tag, " in_ready"},  64'(bus.in_ready), 64'd0);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " outs"},      64'(bus.outs), 64'd0);
    chk({tag, " out_row"},   64'(bus.out_row), 64'd0);
    chk({tag, " out_last"},  64'(bus.out_last), 64'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.ins       = '0;
    bus.ws        = '0;
    bus.out_ready = 1'b1;
    fill_vectors();

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_op(i, 1'b0, -1);

    // start with k_len=0 must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("klen0 busy", 64'(bus.busy), 64'd0);
    chk("klen0 in_ready", 64'(bus.in_ready), 64'd0);

    // identity with random feed gaps and a 3-cycle drain stall on row 1
    run_op(1, 1'b1, 1);

    // reset mid-FLUSH, then a clean run must carry no residue
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 5'd1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.ws       = {R{8'h10}};
    bus.ins      = {C{8'h20}};
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ws       = '0;
    bus.ins      = '0;
    @(negedge clk);
    chk("flush busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_quiet("mid_flush_reset");
    run_op(0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
